chunked_subtractor_seq: RTL and testbench

//  Multi-cycle ripple-borrow subtractor. It is the inverse-direction companion of the
//  3-bit partitioned ripple-carry adder slices. It computes diff = a - b - bin over

---
 rtl/chunked_subtractor_seq_if.sv | 36 +++
 rtl/chunked_subtractor_seq.sv | 103 ++++++++++
 tb/tb_chunked_subtractor_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chunked_subtractor_seq_if.sv
// Operand/result handshake bundle for chunked_subtractor_seq.
// Defining SUB_OVF_FLAG_EN adds the signed-overflow flag ovf to the bundle.
interface chunked_subtractor_seq_if #(
    parameter int unsigned WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_FLAG_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
`endif
endinterface

// File: rtl/chunked_subtractor_seq.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, one CHUNK-bit slice per clock, LSB first.
// Optional macro SUB_OVF_FLAG_EN adds the signed-overflow output ovf.
module chunked_subtractor_seq #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CHUNK = 3
) (
    input logic                     clk,
    input logic                     rst_n,
    chunked_subtractor_seq_if.slave sub
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_reg;
    logic             bout_r;
    logic [CW-1:0]    slice_cnt;
    logic [CHUNK:0]   slice_ext;
    logic             last_slice;
    logic             accept;
`ifdef SUB_OVF_FLAG_EN
    logic             ovf_r;
`endif

    // Operands shift right each RUN cycle, so the current slice is always the bottom CHUNK bits.
    assign slice_ext  = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]}
                      - {{CHUNK{1'b0}}, borrow_reg};
    assign last_slice = (slice_cnt == CW'(N - 1));
    assign accept     = (state == IDLE) && sub.in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        sub.in_ready  = 1'b0;
        sub.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                sub.in_ready = 1'b1;
                if (sub.in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last_slice) state_nx = DONE;
            end
            DONE: begin
                sub.out_valid = 1'b1;
                if (sub.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            diff_r     <= '0;
            borrow_reg <= 1'b0;
            bout_r     <= 1'b0;
            slice_cnt  <= '0;
`ifdef SUB_OVF_FLAG_EN
            ovf_r      <= 1'b0;
`endif
        end else if (accept) begin
            a_sh       <= sub.a;
            b_sh       <= sub.b;
            borrow_reg <= sub.bin;
            slice_cnt  <= '0;
        end else if (state == RUN) begin
            a_sh                               <= a_sh >> CHUNK;
            b_sh                               <= b_sh >> CHUNK;
            diff_r[32'(slice_cnt)*CHUNK +: CHUNK] <= slice_ext[CHUNK-1:0];
            borrow_reg                         <= slice_ext[CHUNK];
            slice_cnt                          <= slice_cnt + 1'b1;
            if (last_slice) begin
                bout_r <= slice_ext[CHUNK];
`ifdef SUB_OVF_FLAG_EN
                // At the last slice the operand MSBs sit at the top of the bottom slice.
                ovf_r  <= (a_sh[CHUNK-1] != b_sh[CHUNK-1]) &&
                          (slice_ext[CHUNK-1] != a_sh[CHUNK-1]);
`endif
            end
        end
    end

    assign sub.diff = diff_r;
    assign sub.bout = bout_r;
`ifdef SUB_OVF_FLAG_EN
    assign sub.ovf  = ovf_r;
`endif
endmodule

// File: tb/tb_chunked_subtractor_seq.sv
// Self-checking bench for chunked_subtractor_seq: behavioural model of a - b - bin plus handshake timing.
// Honours SUB_OVF_FLAG_EN when defined for the whole build.
module tb_chunked_subtractor_seq;
    localparam int unsigned WIDTH = 12;
    localparam int unsigned CHUNK = 3;
    localparam int          N     = WIDTH / CHUNK;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chunked_subtractor_seq_if #(.WIDTH(WIDTH)) bus ();

    chunked_subtractor_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sub   (bus.slave)
    );

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } result_t;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sent   = 0;
    int n_done   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkv(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: the result is the true difference wrapped to WIDTH bits.
    function automatic result_t ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                        input logic bin);
        result_t r;
        longint  d;
        d      = longint'(a) - longint'(b) - longint'(bin);
        r.bout = (d < 0);
        if (d < 0) d = d + (longint'(1) << WIDTH);
        r.diff = WIDTH'(d);
        r.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r.diff[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Model: one outstanding op; out_valid due N+1 negedges after the negedge that saw the accept.
    int      cyc       = 0;
    int      acc_cyc   = 0;
    int      prev_acc  = 0;
    bit      pend      = 1'b0;
    bit      chk_reset = 1'b0;
    bit      b2b       = 1'b0;
    bit      have_prev = 1'b0;
    result_t exp_r;

    always @(negedge clk) begin
        cyc++;
        if (chk_reset) begin
            check1("reset_out_valid", bus.out_valid, 1'b0);
            checkv("reset_diff", bus.diff, '0);
            check1("reset_bout", bus.bout, 1'b0);
`ifdef SUB_OVF_FLAG_EN
            check1("reset_ovf", bus.ovf, 1'b0);
`endif
            chk_reset = 1'b0;
        end
        if (!pend) begin
            check1("idle_in_ready", bus.in_ready, 1'b1);
            check1("idle_out_valid", bus.out_valid, 1'b0);
        end else begin
            check1("busy_in_ready", bus.in_ready, 1'b0);
            check1("out_valid_timing", bus.out_valid, (cyc - acc_cyc) >= N + 1);
            if ((cyc - acc_cyc) >= N + 1) begin
                checkv("diff", bus.diff, exp_r.diff);
                check1("bout", bus.bout, exp_r.bout);
`ifdef SUB_OVF_FLAG_EN
                check1("ovf", bus.ovf, exp_r.ovf);
`endif
            end
        end
        if (rst_n && bus.out_valid && bus.out_ready) n_done++;
        if (!rst_n) begin
            pend      = 1'b0;
            chk_reset = 1'b1;
        end else if (pend) begin
            if ((cyc - acc_cyc) >= N + 1 && bus.out_ready) pend = 1'b0;
        end else if (bus.in_valid) begin
            if (b2b && have_prev) checki("accept_spacing", cyc - prev_acc, N + 2);
            have_prev = b2b;
            prev_acc  = cyc;
            acc_cyc   = cyc;
            pend      = 1'b1;
            exp_r     = ref_sub(bus.a, bus.b, bus.bin);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                n_sent++;
                return;
            end
        end
        check1("accept_timeout", bus.in_ready, 1'b1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) return;
        end
        check1("out_valid_timeout", bus.out_valid, 1'b1);
    endtask

    task automatic expect_out(input string name, input logic [WIDTH-1:0] d, input logic bo);
        wait_valid();
        checkv({name, "_diff"}, bus.diff, d);
        check1({name, "_bout"}, bus.bout, bo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(12'h005, 12'h003, 1'b0); bus.in_valid = 1'b0;
        expect_out("t1", 12'h002, 1'b0);

        send(12'h000, 12'h001, 1'b0); bus.in_valid = 1'b0;
        expect_out("t2a", 12'hFFF, 1'b1);
        send(12'h800, 12'h800, 1'b1); bus.in_valid = 1'b0;
        expect_out("t2b", 12'hFFF, 1'b1);
        send(12'h000, 12'h000, 1'b1); bus.in_valid = 1'b0;
        expect_out("zero_bin", 12'hFFF, 1'b1);
        send(12'h5A5, 12'h5A5, 1'b0); bus.in_valid = 1'b0;
        expect_out("equal", 12'h000, 1'b0);

`ifdef SUB_OVF_FLAG_EN
        send(12'h800, 12'h001, 1'b0); bus.in_valid = 1'b0;
        wait_valid();
        checkv("t3a_diff", bus.diff, 12'h7FF);
        check1("t3a_ovf", bus.ovf, 1'b1);
        @(posedge clk); #1;
        send(12'h7FF, 12'h001, 1'b0); bus.in_valid = 1'b0;
        wait_valid();
        checkv("t3b_diff", bus.diff, 12'h7FE);
        check1("t3b_ovf", bus.ovf, 1'b0);
        @(posedge clk); #1;
`endif

        bus.out_ready = 1'b0;
        send(12'h123, 12'h456, 1'b0); bus.in_valid = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("t4_out_valid", bus.out_valid, 1'b1);
            check1("t4_in_ready", bus.in_ready, 1'b0);
            checkv("t4_diff", bus.diff, 12'hCCD);
            check1("t4_bout", bus.bout, 1'b1);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check1("t4_in_ready_after", bus.in_ready, 1'b1);
        check1("t4_out_valid_after", bus.out_valid, 1'b0);
        @(posedge clk); #1;

        // Reset lands on the edge that ends the second RUN cycle.
        send(12'h0AB, 12'h0CD, 1'b0); bus.in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check1("t5_out_valid", bus.out_valid, 1'b0);
        checkv("t5_diff", bus.diff, '0);
        check1("t5_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check1("t5_no_result", bus.out_valid, 1'b0);
        end
        @(posedge clk); #1;

        bus.out_ready = 1'b1;
        b2b           = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 8 == 0) ? ra : WIDTH'($urandom);
            send(ra, rb, 1'($urandom));
        end
        bus.in_valid = 1'b0;
        b2b          = 1'b0;
        for (int i = 0; i < 20 && pend; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checki("ops_completed", n_done, n_sent - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed", n_fail, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
